// File: rtl/aer_event_dispatch_scheduler.sv
// -----------------------------------------------------------------------------
// aer_event_dispatch_scheduler
//
// Buffers merged AER events coming from the core event arbiter and dispatches
// each one to its destination core(s) over per-core 4-phase req/ack links.
// A normal event goes to the next core in the ring (source+1, wrapping). An
// event whose neuron address starts with 2'b01 is broadcast to every core.
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in_req      in   4-phase event request from the arbiter
//   in_addr     in   {src_core, neuron_addr}, stable while in_req=1
//   in_ack      out  event accepted into the FIFO (4-phase acknowledge)
//   dst_req     out  per-core request, one bit per core
//   dst_addr    out  neuron address shared by all destination links
//   dst_ack     in   per-core acknowledge
//   fifo_count  out  number of events currently held in the FIFO
//   busy        out  FIFO non-empty or a delivery still in progress
//
// Every output is driven straight from a flop.
// -----------------------------------------------------------------------------
module aer_event_dispatch_scheduler #(
  parameter int CORE_NUM      = 4,
  parameter int AER_OUT_WIDTH = 8,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_req,
  input  logic [AER_OUT_WIDTH+$clog2(CORE_NUM)-1:0] in_addr,
  output logic                                      in_ack,
  output logic [CORE_NUM-1:0]                       dst_req,
  output logic [AER_OUT_WIDTH-1:0]                  dst_addr,
  input  logic [CORE_NUM-1:0]                       dst_ack,
  output logic [$clog2(FIFO_DEPTH):0]               fifo_count,
  output logic                                      busy
);

  localparam int SRC_W   = $clog2(CORE_NUM);
  localparam int ENTRY_W = AER_OUT_WIDTH + SRC_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  typedef enum logic {I_IDLE, I_ACK} in_state_t;
  typedef enum logic [1:0] {O_IDLE, O_REQ, O_WAIT} out_state_t;

  // Destination mask of one buffered entry: broadcast on prefix 01,
  // otherwise the next core in the ring.
  function automatic logic [CORE_NUM-1:0] route_mask(input logic [ENTRY_W-1:0] entry);
    logic [SRC_W-1:0]         src;
    logic [AER_OUT_WIDTH-1:0] na;
    int                       dst;
    src        = entry[ENTRY_W-1 -: SRC_W];
    na         = entry[AER_OUT_WIDTH-1:0];
    route_mask = '0;
    dst        = 0;
    if (na[AER_OUT_WIDTH-1 -: 2] == 2'b01) begin
      route_mask = {CORE_NUM{1'b1}};
    end else begin
      dst             = (int'(src) + 32'sd1) % CORE_NUM;
      route_mask[dst] = 1'b1;
    end
  endfunction

  logic [ENTRY_W-1:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [CNT_W-1:0]         cnt_r;
  in_state_t                in_state_r;
  out_state_t               out_state_r;
  logic                     in_ack_r;
  logic [CORE_NUM-1:0]      dst_req_r;
  logic [AER_OUT_WIDTH-1:0] dst_addr_r;
  logic [CORE_NUM-1:0]      mask_r;
  logic [CORE_NUM-1:0]      seen_r;
  logic                     busy_r;

  logic                     push_s;
  logic                     pop_s;
  logic [ENTRY_W-1:0]       head_s;
  logic [CORE_NUM-1:0]      head_mask_s;
  logic [CORE_NUM-1:0]      ack_hit_s;
  logic [CORE_NUM-1:0]      covered_s;
  logic [CNT_W-1:0]         cnt_nxt_s;

  assign in_ack     = in_ack_r;
  assign dst_req    = dst_req_r;
  assign dst_addr   = dst_addr_r;
  assign fifo_count = cnt_r;
  assign busy       = busy_r;

  // Push/pop decisions use the count before the edge, so a pop never frees
  // room for a write in the same cycle.
  always_comb begin
    push_s      = (in_state_r == I_IDLE) && in_req && (cnt_r < CNT_W'(FIFO_DEPTH));
    pop_s       = (out_state_r == O_IDLE) && (cnt_r != '0);
    head_s      = mem_r[rd_ptr_r];
    head_mask_s = route_mask(head_s);
    ack_hit_s   = dst_ack & mask_r;
    covered_s   = seen_r | ack_hit_s;
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
      2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Event storage; contents need no reset since the count qualifies them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_addr;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      cnt_r <= cnt_nxt_s;
    end
  end

  // Input handshake: one FIFO write per full 4-phase cycle on in_req/in_ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_r <= I_IDLE;
      in_ack_r   <= 1'b0;
    end else begin
      case (in_state_r)
        I_IDLE: begin
          if (push_s) begin
            in_ack_r   <= 1'b1;
            in_state_r <= I_ACK;
          end
        end
        I_ACK: begin
          if (!in_req) begin
            in_ack_r   <= 1'b0;
            in_state_r <= I_IDLE;
          end
        end
        default: begin
          in_ack_r   <= 1'b0;
          in_state_r <= I_IDLE;
        end
      endcase
    end
  end

  // Output dispatch: each targeted link completes independently; the event is
  // retired only once every targeted ack has been seen high and then low.
  // busy is computed from next-state values so it stays a registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state_r <= O_IDLE;
      dst_req_r   <= '0;
      dst_addr_r  <= '0;
      mask_r      <= '0;
      seen_r      <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (out_state_r)
        O_IDLE: begin
          if (pop_s) begin
            dst_addr_r  <= head_s[AER_OUT_WIDTH-1:0];
            dst_req_r   <= head_mask_s;
            mask_r      <= head_mask_s;
            seen_r      <= '0;
            out_state_r <= O_REQ;
            busy_r      <= 1'b1;
          end else begin
            busy_r <= (cnt_nxt_s != '0);
          end
        end
        O_REQ: begin
          dst_req_r <= dst_req_r & ~ack_hit_s;
          seen_r    <= covered_s;
          busy_r    <= 1'b1;
          if (covered_s == mask_r) begin
            out_state_r <= O_WAIT;
          end
        end
        O_WAIT: begin
          if (ack_hit_s == '0) begin
            out_state_r <= O_IDLE;
            busy_r      <= (cnt_nxt_s != '0);
          end else begin
            busy_r <= 1'b1;
          end
        end
        default: begin
          out_state_r <= O_IDLE;
          dst_req_r   <= '0;
          busy_r      <= (cnt_nxt_s != '0);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aer_event_dispatch_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for aer_event_dispatch_scheduler. A queue-based model tracks accepted
// events and the delivery in progress; one compare routine checks every DUT
// output against it after every clock edge. Directed scenarios add literal
// expectations; random phases drive producer and per-core responders.
// -----------------------------------------------------------------------------
module tb_aer_event_dispatch_scheduler;

  logic       clk;
  logic       rst_n;
  logic       in_req;
  logic [9:0] in_addr;
  logic       in_ack;
  logic [3:0] dst_req;
  logic [7:0] dst_addr;
  logic [3:0] dst_ack;
  logic [3:0] fifo_count;
  logic       busy;

  aer_event_dispatch_scheduler #(
    .CORE_NUM(4), .AER_OUT_WIDTH(8), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_addr(in_addr),
    .in_ack(in_ack), .dst_req(dst_req), .dst_addr(dst_addr),
    .dst_ack(dst_ack), .fifo_count(fifo_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  logic [9:0] mq[$];
  bit         m_in_ack;
  bit   [3:0] m_req;
  bit   [3:0] m_mask;
  bit   [3:0] m_got;
  bit   [7:0] m_addr;
  bit         m_active;
  bit         m_allacked;
  int         n_accepted = 0;

  // stimulus agents
  int ack_mode    = 0;   // 0 manual, 1 immediate echo, 2 random delay
  bit prod_active = 0;
  bit prod_fast   = 0;
  int prod_left   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event at %0t", name, $time);
  endtask

  function automatic bit [3:0] spec_mask(input bit [9:0] e);
    int dst;
    if (e[7:6] == 2'b01) return 4'hF;
    dst = (int'(e[9:8]) + 1) % 4;
    return 4'(1 << dst);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_in_ack   = 0;
    m_req      = 4'h0;
    m_mask     = 4'h0;
    m_got      = 4'h0;
    m_addr     = 8'h00;
    m_active   = 0;
    m_allacked = 0;
  endtask

  // One clock edge worth of behaviour, using the inputs present at that edge.
  task automatic model_step();
    bit       push;
    bit       pop;
    bit [9:0] h;
    bit [3:0] hit;
    push = !m_in_ack && in_req && (mq.size() < 8);
    pop  = !m_active && (mq.size() > 0);
    hit  = dst_ack & m_mask;
    if (m_in_ack) begin
      if (!in_req) m_in_ack = 0;
    end else if (push) begin
      m_in_ack = 1;
    end
    if (m_active) begin
      if (!m_allacked) begin
        m_req = m_req & ~hit;
        m_got = m_got | hit;
        if (m_got == m_mask) m_allacked = 1;
      end else if (hit == 4'h0) begin
        m_active = 0;
      end
    end
    if (pop) begin
      h          = mq.pop_front();
      m_addr     = h[7:0];
      m_mask     = spec_mask(h);
      m_req      = m_mask;
      m_got      = 4'h0;
      m_allacked = 0;
      m_active   = 1;
    end
    if (push) begin
      mq.push_back(in_addr);
      n_accepted++;
    end
  endtask

  task automatic compare();
    check("in_ack", 32'(in_ack), 32'(m_in_ack));
    check("dst_req", 32'(dst_req), 32'(m_req));
    check("dst_addr", 32'(dst_addr), 32'(m_addr));
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("busy", 32'(busy), 32'((mq.size() != 0) || m_active));
  endtask

  function automatic logic [9:0] gen_addr();
    logic [9:0] a;
    a = 10'($urandom);
    if ($urandom_range(0, 3) == 0) a[7:6] = 2'b01;
    return a;
  endfunction

  task automatic agents();
    if (prod_active) begin
      if (in_req && in_ack) begin
        if (prod_fast || $urandom_range(0, 2) != 0) in_req = 1'b0;
      end else if (!in_req && !in_ack && prod_left > 0) begin
        if (prod_fast || $urandom_range(0, 2) == 0) begin
          in_addr = gen_addr();
          in_req  = 1'b1;
          prod_left--;
        end
      end
    end
    if (ack_mode != 0) begin
      for (int i = 0; i < 4; i++) begin
        if (!dst_ack[i] && dst_req[i]) begin
          if (ack_mode == 1 || $urandom_range(0, 2) == 0) dst_ack[i] = 1'b1;
        end else if (dst_ack[i] && !dst_req[i]) begin
          if (ack_mode == 1 || $urandom_range(0, 2) == 0) dst_ack[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) model_step();
    else model_reset();
    compare();
    agents();
  endtask

  task automatic send_one(input logic [9:0] a);
    int n;
    in_addr = a;
    in_req  = 1'b1;
    n = 0;
    while (!in_ack && n < 50) begin tick(); n++; end
    if (!in_ack) timeout("in_ack_rise");
    in_req = 1'b0;
    n = 0;
    while (in_ack && n < 50) begin tick(); n++; end
    if (in_ack) timeout("in_ack_fall");
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (dst_req == 4'h0 && n < 50) begin tick(); n++; end
    if (dst_req == 4'h0) timeout("dst_req_rise");
  endtask

  task automatic run_until_done(input int bound);
    int n;
    n = 0;
    while ((prod_left > 0 || in_req || in_ack || busy) && n < bound) begin tick(); n++; end
    if (prod_left > 0 || in_req || in_ack || busy) timeout("drain");
  endtask

  initial begin
    logic [3:0] e;
    int         acc0;
    rst_n   = 1'b0;
    in_req  = 1'b0;
    in_addr = 10'h000;
    dst_ack = 4'h0;
    model_reset();
    #7;
    check("rst_in_ack", 32'(in_ack), 32'h0);
    check("rst_dst_req", 32'(dst_req), 32'h0);
    check("rst_dst_addr", 32'(dst_addr), 32'h0);
    check("rst_fifo_count", 32'(fifo_count), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    #5 rst_n = 1'b1;

    // single event, next-core routing
    ack_mode = 1;
    send_one(10'h008);
    wait_req();
    check("t1_req", 32'(dst_req), 32'h2);
    check("t1_addr", 32'(dst_addr), 32'h08);
    run_until_done(50);
    check("t1_busy", 32'(busy), 32'h0);
    check("t1_count", 32'(fifo_count), 32'h0);

    // ring wrap from the last core
    send_one(10'h310);
    wait_req();
    check("t2_req", 32'(dst_req), 32'h1);
    check("t2_addr", 32'(dst_addr), 32'h10);
    run_until_done(50);

    // broadcast with staggered acks
    ack_mode = 0;
    send_one(10'h241);
    wait_req();
    check("t3_req", 32'(dst_req), 32'hF);
    check("t3_addr", 32'(dst_addr), 32'h41);
    for (int k = 0; k < 4; k++) begin
      dst_ack[k] = 1'b1;
      tick();
      e = 4'(4'hF << (k + 1));
      check("t3_drop", 32'(dst_req), 32'(e));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      dst_ack[k] = 1'b0;
      tick();
      check("t3_wait_busy", 32'(busy), 32'h1);
    end
    dst_ack[3] = 1'b0;
    tick();
    check("t3_idle_busy", 32'(busy), 32'h0);
    tick();
    check("t3_no_redeliver", 32'(dst_req), 32'h0);

    // full FIFO with acks held low
    acc0        = n_accepted;
    prod_active = 1;
    prod_fast   = 1;
    prod_left   = 10;
    repeat (60) tick();
    check("t4_count_full", 32'(fifo_count), 32'h8);
    check("t4_stall_ack", 32'(in_ack), 32'h0);
    check("t4_accepted", 32'(n_accepted - acc0), 32'd9);
    ack_mode = 1;
    run_until_done(500);
    check("t4_all_accepted", 32'(n_accepted - acc0), 32'd10);

    // back-to-back stream while draining
    prod_left = 20;
    run_until_done(1000);

    // asynchronous reset mid-delivery
    prod_active = 0;
    ack_mode    = 0;
    send_one(10'h055);
    wait_req();
    check("t6_req_before", 32'(dst_req), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    check("t6_in_ack", 32'(in_ack), 32'h0);
    check("t6_dst_req", 32'(dst_req), 32'h0);
    check("t6_dst_addr", 32'(dst_addr), 32'h0);
    check("t6_count", 32'(fifo_count), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    model_reset();
    tick();
    #2 rst_n = 1'b1;
    ack_mode = 1;
    send_one(10'h122);
    wait_req();
    check("t6_req_after", 32'(dst_req), 32'h4);
    check("t6_addr_after", 32'(dst_addr), 32'h22);
    run_until_done(50);

    // random traffic, random responders
    ack_mode    = 2;
    prod_active = 1;
    prod_fast   = 0;
    prod_left   = 200;
    run_until_done(20000);
    prod_fast = 1;
    prod_left = 200;
    run_until_done(20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
